// File: rtl/bcd_div_pkg.sv
// Shared types and constants for the BCD divider scheduler.
// Holds the FSM encoding, response status codes and the BCD nibble check.
package bcd_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DIVZERO = 2'b01;
    localparam logic [1:0] ST_BADBCD  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    // Worst-case divider latency: 9999 / 1 takes 4 + 3*9999 cycles.
    localparam int DIV_MAX_LATENCY = 30001;

    // True when every nibble of the 4-digit word is a decimal digit.
    function automatic logic is_bcd16(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_div_scheduler_rr_grant.sv
// Combinational round-robin picker.
// Ports: req (pending mask), ptr (search start) -> grant (one-hot), idx, any.
module rr_grant #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] j;

    // Walk from ptr upwards, wrapping; the first pending bit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/bcd_div_scheduler.sv
// Shares one external BCD divider between N_REQ requesters: round-robin
// accept, operand screening, clear/start/wait sequencing with a watchdog.
// Ports: clk, rst (sync, active high); req_valid/req_dividend/req_divisor in,
// req_ready out; rsp_valid/rsp_quotient/rsp_remainder/rsp_status out; busy;
// div_rst/div_start/div_dividend/div_divisor to the divider,
// div_quotient/div_remainder/div_end from it.
module bcd_div_scheduler
    import bcd_div_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 32767
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*16-1:0] req_dividend,
    input  logic [N_REQ*16-1:0] req_divisor,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [15:0]        rsp_quotient,
    output logic [15:0]        rsp_remainder,
    output logic [1:0]         rsp_status,
    output logic               busy,
    output logic               div_rst,
    output logic               div_start,
    output logic [15:0]        div_dividend,
    output logic [15:0]        div_divisor,
    input  logic [15:0]        div_quotient,
    input  logic [15:0]        div_remainder,
    input  logic               div_end
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] g_idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;

    logic [15:0] sel_dd;
    logic [15:0] sel_dv;
    logic        div_zero;
    logic        bad_bcd;

    logic accept;
    logic done;
    logic timeout;

    rr_grant #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign sel_dd   = req_dividend[int'(gnt_idx)*16 +: 16];
    assign sel_dv   = req_divisor[int'(gnt_idx)*16 +: 16];
    assign div_zero = (sel_dv == 16'h0000);
    assign bad_bcd  = !is_bcd16(sel_dd) || !is_bcd16(sel_dv);
    assign cnt_inc  = cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                // Hold off grants while reset is asserted.
                if (gnt_any && !rst) begin
                    accept    = 1'b1;
                    req_ready = gnt;
                    if (div_zero || bad_bcd) state_nxt = S_RESP;
                    else                     state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (div_end) begin
                    done      = 1'b1;
                    state_nxt = S_RESP;
                end else if (cnt_inc == TO_LIMIT) begin
                    timeout   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[g_idx] = 1'b1;
                state_nxt        = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            g_idx         <= '0;
            cnt           <= '0;
            div_rst       <= 1'b1;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_status    <= ST_OK;
        end else begin
            // The divider keeps its quotient across runs, so every run is
            // preceded by a clear; a timed-out run is cleared afterwards.
            div_rst   <= (state_nxt == S_CLEAR) || timeout;
            div_start <= (state_nxt == S_START);

            if (state == S_WAIT) cnt <= cnt_inc;
            else                 cnt <= '0;

            if (accept) begin
                g_idx         <= gnt_idx;
                div_dividend  <= sel_dd;
                div_divisor   <= sel_dv;
                rsp_quotient  <= '0;
                rsp_remainder <= '0;
                if (div_zero)     rsp_status <= ST_DIVZERO;
                else if (bad_bcd) rsp_status <= ST_BADBCD;
                else              rsp_status <= ST_OK;
            end

            if (done) begin
                rsp_quotient  <= div_quotient;
                rsp_remainder <= div_remainder;
                rsp_status    <= ST_OK;
            end

            if (timeout) begin
                rsp_quotient  <= '0;
                rsp_remainder <= '0;
                rsp_status    <= ST_TIMEOUT;
            end

            if (state == S_RESP) begin
                ptr <= (g_idx == LAST_IDX) ? '0 : g_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_div_scheduler.sv
// Self-checking bench for bcd_div_scheduler against a decimal-arithmetic
// reference model, with a behavioural divider and a never-ending stub.
module tb_bcd_div_scheduler;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]    req_valid = '0;
    logic [N*16-1:0] req_dividend = '0;
    logic [N*16-1:0] req_divisor = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_quotient;
    logic [15:0]     rsp_remainder;
    logic [1:0]      rsp_status;
    logic            busy;
    logic            div_rst;
    logic            div_start;
    logic [15:0]     div_dividend;
    logic [15:0]     div_divisor;
    logic [15:0]     div_quotient;
    logic [15:0]     div_remainder;
    logic            div_end;

    logic [N-1:0]    t_req_valid = '0;
    logic [N*16-1:0] t_req_dividend = '0;
    logic [N*16-1:0] t_req_divisor = '0;
    logic [N-1:0]    t_req_ready;
    logic [N-1:0]    t_rsp_valid;
    logic [15:0]     t_rsp_quotient;
    logic [15:0]     t_rsp_remainder;
    logic [1:0]      t_rsp_status;
    logic            t_busy;
    logic            t_div_rst;
    logic            t_div_start;
    logic [15:0]     t_div_dividend;
    logic [15:0]     t_div_divisor;

    bcd_div_scheduler #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dividend(req_dividend),
        .req_divisor(req_divisor), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder), .rsp_status(rsp_status),
        .busy(busy), .div_rst(div_rst), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_end(div_end)
    );

    bcd_div_scheduler #(.N_REQ(N), .TIMEOUT(10)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid(t_req_valid), .req_dividend(t_req_dividend),
        .req_divisor(t_req_divisor), .req_ready(t_req_ready),
        .rsp_valid(t_rsp_valid), .rsp_quotient(t_rsp_quotient),
        .rsp_remainder(t_rsp_remainder), .rsp_status(t_rsp_status),
        .busy(t_busy), .div_rst(t_div_rst), .div_start(t_div_start),
        .div_dividend(t_div_dividend), .div_divisor(t_div_divisor),
        .div_quotient(16'h0000), .div_remainder(16'h0000),
        .div_end(1'b0)
    );

    function automatic int from_bcd(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 +
               int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        int x;
        x = v % 10000;
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic bit bcd_ok(input logic [15:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[4*k +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Behavioural divider: quotient accumulates unless cleared, result
    // appears 4 + 3q cycles after the start cycle.
    int m_q = 0;
    int m_r = 0;
    int m_end = 0;
    bit m_act = 1'b0;
    always @(posedge clk) begin : div_model
        int a;
        int b;
        if (div_rst) begin
            m_q   <= 0;
            m_r   <= 0;
            m_act <= 1'b0;
        end else if (div_start) begin
            a = from_bcd(div_dividend);
            b = from_bcd(div_divisor);
            if (b == 0) b = 1;
            m_q   <= m_q + a / b;
            m_r   <= a % b;
            m_end <= cyc + 4 + 3 * (a / b);
            m_act <= 1'b1;
        end else if (div_end) begin
            m_act <= 1'b0;
        end
    end
    assign div_end       = m_act && (cyc == m_end);
    assign div_quotient  = to_bcd(m_q);
    assign div_remainder = to_bcd(m_r);

    int n_start = 0;
    always @(posedge clk) if (div_start === 1'b1) n_start <= n_start + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_div_rst", 32'(div_rst), 1);
        check("rst_div_start", 32'(div_start), 0);
        check("rst_div_dd", 32'(div_dividend), 0);
        check("rst_div_dv", 32'(div_divisor), 0);
        check("rst_quot", 32'(rsp_quotient), 0);
        check("rst_rem", 32'(rsp_remainder), 0);
        check("rst_status", 32'(rsp_status), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        req_valid = '0;
        t_req_valid = '0;
        @(negedge clk);
        check("rel_div_rst", 32'(div_rst), 0);
    endtask

    task automatic do_op(input int i, input logic [15:0] dd,
                         input logic [15:0] dv);
        int a_cyc, lat, st, q, r, nst, s0;
        bit got;
        if (dv == 16'h0000) begin
            st = 1; lat = 1; nst = 0; q = 0; r = 0;
        end else if (!bcd_ok(dd) || !bcd_ok(dv)) begin
            st = 2; lat = 1; nst = 0; q = 0; r = 0;
        end else begin
            q = from_bcd(dd) / from_bcd(dv);
            r = from_bcd(dd) % from_bcd(dv);
            st = 0; lat = 7 + 3 * q; nst = 1;
        end
        @(negedge clk);
        req_dividend[i*16 +: 16] = dd;
        req_divisor[i*16 +: 16]  = dv;
        req_valid[i] = 1'b1;
        #1;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (req_ready[i]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("grant", 32'(got), 1);
        if (!got) begin
            req_valid[i] = 1'b0;
            return;
        end
        check("ready_onehot", 32'(req_ready), 32'(1 << i));
        a_cyc = cyc;
        s0 = n_start;
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < lat + 20; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                got = 1'b1;
                break;
            end
        end
        check("rsp_seen", 32'(got), 1);
        if (!got) return;
        check("latency", 32'(cyc - a_cyc), 32'(lat));
        check("rsp_onehot", 32'(rsp_valid), 32'(1 << i));
        check("status", 32'(rsp_status), 32'(st));
        if (st == 0) begin
            check("quotient", 32'(rsp_quotient), 32'(to_bcd(q)));
            check("remainder", 32'(rsp_remainder), 32'(to_bcd(r)));
        end
        check("start_pulses", 32'(n_start - s0), 32'(nst));
    endtask

    initial begin : main
        int order[$];
        int exp_order[5];
        int drop, n_rsp, a_cyc, idx, cnt_rsp;
        bit re0, got;
        logic [15:0] dd, dv;

        do_reset();

        do_op(0, 16'h0100, 16'h0007);
        do_op(1, 16'h0005, 16'h0009);
        do_op(1, 16'h0009, 16'h0003);
        do_op(2, 16'h0010, 16'h0000);
        do_op(3, 16'h00A0, 16'h0001);
        do_op(0, 16'hA000, 16'h0000);
        do_op(2, 16'h9999, 16'h9999);
        do_op(3, 16'h9999, 16'h0099);
        do_op(1, 16'h0000, 16'h0001);

        for (int n = 0; n < 20; n++) begin
            int i, kind, a, b;
            i = $urandom_range(0, N - 1);
            kind = $urandom_range(0, 9);
            b = $urandom_range(1, 200);
            a = b * $urandom_range(0, 30) + $urandom_range(0, b - 1);
            if (a > 9999) a = 9999;
            dd = to_bcd(a);
            dv = to_bcd(b);
            if (kind == 0) begin
                dv = 16'h0000;
                if ($urandom_range(0, 1) == 1) dd[7:4] = 4'hC;
            end else if (kind == 1) begin
                if ($urandom_range(0, 1) == 1)
                    dd[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
                else
                    dv[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            end
            do_op(i, dd, dv);
        end

        // Round-robin after reset: all four at once, then 0 again.
        do_reset();
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            req_dividend[i*16 +: 16] = 16'h0010;
            req_divisor[i*16 +: 16]  = 16'h0002;
        end
        req_valid = '1;
        #1;
        drop = -1;
        n_rsp = 0;
        re0 = 1'b0;
        for (int k = 0; k < 2000 && n_rsp < 5; k++) begin
            if (rsp_valid != '0) begin
                check("rr_quot", 32'(rsp_quotient), 32'h0005);
                if (n_rsp < order.size())
                    check("rr_rsp_onehot", 32'(rsp_valid), 32'(1 << order[n_rsp]));
                n_rsp++;
            end
            if (req_ready != '0 && order.size() < 5) begin
                idx = 0;
                for (int j = 0; j < N; j++) if (req_ready[j]) idx = j;
                order.push_back(idx);
                drop = idx;
            end
            @(negedge clk);
            if (drop >= 0) begin
                req_valid[drop] = 1'b0;
                if (drop == 0 && !re0) begin
                    re0 = 1'b1;
                    req_valid[0] = 1'b1;
                end
                drop = -1;
            end
        end
        check("rr_rsp_count", 32'(n_rsp), 5);
        check("rr_grant_count", 32'(order.size()), 5);
        for (int j = 0; j < 5; j++) begin
            if (j < order.size())
                check($sformatf("rr_order%0d", j), 32'(order[j]), 32'(exp_order[j]));
        end

        // Watchdog: stub divider never ends.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            idx = 2 + t;
            t_req_dividend[idx*16 +: 16] = 16'h0009;
            t_req_divisor[idx*16 +: 16]  = 16'h0003;
            t_req_valid[idx] = 1'b1;
            #1;
            got = 1'b0;
            for (int k = 0; k < 50; k++) begin
                if (t_req_ready[idx]) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("to_grant", 32'(got), 1);
            a_cyc = cyc;
            @(posedge clk);
            #1 t_req_valid[idx] = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (t_rsp_valid != '0) begin
                    got = 1'b1;
                    break;
                end
                check("to_no_early_rst", 32'(t_div_rst && (cyc - a_cyc) > 1), 0);
            end
            check("to_rsp_seen", 32'(got), 1);
            check("to_latency", 32'(cyc - a_cyc), 13);
            check("to_onehot", 32'(t_rsp_valid), 32'(1 << idx));
            check("to_status", 32'(t_rsp_status), 3);
            check("to_quot", 32'(t_rsp_quotient), 0);
            check("to_rem", 32'(t_rsp_remainder), 0);
            check("to_div_rst", 32'(t_div_rst), 1);
            @(negedge clk);
            check("to_div_rst_end", 32'(t_div_rst), 0);
            check("to_idle", 32'(t_busy), 0);
        end

        // Reset in the middle of a long WAIT.
        @(negedge clk);
        req_dividend[15:0] = 16'h0900;
        req_divisor[15:0]  = 16'h0003;
        req_valid[0] = 1'b1;
        #1;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (req_ready[0]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ab_grant", 32'(got), 1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("ab_busy", 32'(busy), 1);
        rst = 1'b1;
        req_divisor[31:16] = 16'h0001;
        req_valid[1] = 1'b1;
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        req_valid = '0;
        cnt_rsp = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) cnt_rsp++;
        end
        check("ab_no_rsp", 32'(cnt_rsp), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_div_scheduler.md
# bcd_div_scheduler

Shares one `bcd_divider` between `N_REQ` requesters. Requests are accepted round-robin. Operands are screened before any divider cycle is spent: divide-by-zero and non-BCD nibbles are rejected. Each accepted operation is sequenced as clear, then start, then wait, with a watchdog. The result is returned to the owning requester as a one-cycle response pulse.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 32767: maximum cycles in WAIT before abort; exceeds the worst-case divider latency of 30001.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `req_valid` in `N_REQ`: request pending, one bit per requester.
- `req_dividend` in `N_REQ*16`: BCD dividend; requester i occupies bits `[16i+15:16i]`.
- `req_divisor` in `N_REQ*16`: BCD divisor, same packing.
- `req_ready` out `N_REQ`: one-hot accept strobe.
- `rsp_valid` out `N_REQ`: one-hot, one-cycle response pulse.
- `rsp_quotient` out 16: BCD quotient; valid only with `rsp_valid`.
- `rsp_remainder` out 16: BCD remainder; valid only with `rsp_valid`.
- `rsp_status` out 2: 00 ok, 01 divide-by-zero, 10 non-BCD operand, 11 timeout.
- `busy` out 1: high in every state except IDLE.
- `div_rst` out 1: registered reset to the divider.
- `div_start` out 1: registered start pulse to the divider.
- `div_dividend` out 16: registered operand to the divider.
- `div_divisor` out 16: registered operand to the divider.
- `div_quotient` in 16: result from the divider.
- `div_remainder` in 16: result from the divider.
- `div_end` in 1: divider `end_division`.

## Operation
- States: IDLE, CLEAR, START, WAIT, RESP.
- **IDLE**
  - Grant g is the lowest index ≥ `ptr` (wrapping) whose `req_valid` is high.
  - `req_ready[g]` is driven combinationally, high this cycle only.
  - The operands of g are captured into internal registers, and g is latched.
  - Screening, decided in the same cycle:
    - divisor == 0000 → status 01, next state RESP;
    - else any nibble > 9 in either operand → status 10, next state RESP;
    - else → CLEAR.
  - Divide-by-zero has priority over the non-BCD check.
- **CLEAR**
  - `div_rst` = 1 for exactly one cycle.
  - This clear is mandatory: the divider does not clear its quotient between operations.
- **START**
  - `div_start` = 1 for exactly one cycle.
  - `div_dividend` and `div_divisor` carry the captured operands. They hold from CLEAR until the exit from WAIT.
- **WAIT**
  - The watchdog counter increments each cycle.
  - On `div_end`: capture `div_quotient` and `div_remainder`, status 00, next state RESP.
  - Else, when the counter reaches `TIMEOUT`: status 11, quotient and remainder 0000, `div_rst` = 1 on the next cycle, next state RESP.
- **RESP**
  - `rsp_valid[g]` = 1.
  - `ptr` ← (g+1) mod `N_REQ`.
  - Next state IDLE.
- `div_end` outside WAIT is ignored.
- Requesters must hold `req_valid` and operands until `req_ready`. A withdrawn request is never granted.
- A new request may be accepted in the IDLE cycle that immediately follows RESP.
- Reset values:
  - state IDLE, `ptr` 0;
  - `req_ready`, `rsp_valid`, `div_start`, `busy` all 0;
  - `rsp_*` and `div_dividend`/`div_divisor` 0;
  - `div_rst` 1, so the divider is cleared alongside the scheduler, then 0 from the first IDLE cycle.
- Reset during any state aborts the operation. No response is issued for the aborted request.

## Timing
- Divider latency is measured from its start cycle to its `div_end` cycle: 4 + 3q cycles, where q is the decimal quotient.
- Accept at cycle A:
  - CLEAR at A+1;
  - START at A+2;
  - `div_end` at A+6+3q;
  - `rsp_valid` at A+7+3q;
  - IDLE at A+8+3q.
- Rejected request: accept at A, `rsp_valid` at A+1.
- Timeout response: `TIMEOUT`+1 cycles after START.
- Throughput is one operation in flight. `req_ready` is never asserted outside IDLE.

## Structure
- Shared package `bcd_div_pkg` holds:
  - the state encoding;
  - the `rsp_status` codes `ST_OK`, `ST_DIVZERO`, `ST_BADBCD`, `ST_TIMEOUT`;
  - the constant 30001 as `DIV_MAX_LATENCY`.
- One sub-module, `rr_grant`: combinational round-robin picker taking `req_valid` and `ptr`, producing a one-hot grant and an index.
- The BCD nibble check is an inline function in the package.
- The divider is not instantiated here. A top level wires the `div_*` ports to `bcd_divider`.

## Test plan
- Requester 0 sends 0100 / 0007 → `rsp_valid[0]` at A+49, quotient 0014, remainder 0002, status 00.
- Requester 1 sends 0005 / 0009 → `rsp_valid[1]` at A+7, quotient 0000, remainder 0005. A back-to-back 0009 / 0003 then returns 0003 / 0000, proving the quotient is cleared.
- All four requesters assert together after reset with 0010 / 0002 → served in order 0, 1, 2, 3, each quotient 0005. A re-asserted requester 0 is served after 3.
- Divisor 0000 → status 01 at A+1, no `div_start` pulse. Dividend 00A0 with divisor 0001 → status 10.
- `TIMEOUT` = 10 with a stub divider that never asserts `div_end` → status 11 at START+11, a one-cycle `div_rst`, and the next request is accepted normally.
- `rst` asserted during WAIT → the next cycle shows all outputs at reset values with `div_rst` = 1, and no `rsp_valid` for the aborted request.
